// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side character buffer between the UART receiver and the CSR block.
// Characters (9-bit data plus 2 error flags) arrive as one-cycle pulses with no
// back-pressure. They are held in a first-in first-out store and presented
// show-ahead to the CSR read path through a valid/ready handshake. The block
// also reports fill level, a programmable fill-threshold interrupt, sticky
// overrun status, and drives RTS with watermark hysteresis.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   wr_d_i         received character
//   wr_err_i       [0] parity error, [1] framing error
//   wr_valid_i     one-cycle write pulse
//   rd_d_o         head character (show-ahead)
//   rd_err_o       head character error flags
//   rd_valid_o     head entry is valid (buffer not empty)
//   rd_ready_i     consumer pops the head when rd_valid_o is high
//   flush_i        discard all entries
//   thresh_i       interrupt threshold, 0 disables
//   level_o        current number of entries
//   empty_o        level_o == 0
//   full_o         level_o == DEPTH
//   overrun_o      sticky: a character was dropped
//   overrun_clr_i  clears overrun_o
//   thresh_irq_o   level_o >= thresh_i and thresh_i != 0
//   rts_n_o        active-low request-to-send
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int RTS_HIGH_WM = 12,
  parameter int RTS_LOW_WM  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8:0]                 wr_d_i,
  input  logic [1:0]                 wr_err_i,
  input  logic                       wr_valid_i,
  output logic [8:0]                 rd_d_o,
  output logic [1:0]                 rd_err_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  input  logic                       flush_i,
  input  logic [$clog2(DEPTH):0]     thresh_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       overrun_o,
  input  logic                       overrun_clr_i,
  output logic                       thresh_irq_o,
  output logic                       rts_n_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_HIGH = LW'(RTS_HIGH_WM);
  localparam logic [LW-1:0] LVL_LOW  = LW'(RTS_LOW_WM);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    RTS_ASSERTED   = 1'b0,
    RTS_DEASSERTED = 1'b1
  } rts_state_e;

  // Storage entries are {err[1:0], data[8:0]}; contents are never reset.
  logic [10:0]     mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q,  level_d;
  logic            overrun_q, overrun_d;
  rts_state_e      rts_state_q, rts_state_d;
  logic            rts_n_q,  rts_n_d;

  logic            rd_hs_s;
  logic            wr_acc_s;
  logic            wr_drop_s;
  logic            mem_we_s;
  logic [10:0]     rd_entry_s;

  // Handshake qualification: a full buffer still accepts a write when the
  // head is popped in the same cycle, so nothing is lost in that case.
  always_comb begin
    rd_hs_s   = (level_q != LVL_ZERO) && rd_ready_i;
    wr_acc_s  = wr_valid_i && ((level_q != LVL_FULL) || rd_hs_s);
    wr_drop_s = wr_valid_i && !wr_acc_s;
  end

  // Pointer and level next-state; flush overrides any concurrent read/write.
  always_comb begin
    mem_we_s = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      mem_we_s = 1'b0;
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      mem_we_s = wr_acc_s;
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_hs_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_hs_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Sticky overrun: a drop wins over a simultaneous clear. A write discarded
  // by flush is not counted as a drop.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_drop_s && !flush_i) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // RTS hysteresis evaluated on the next level so rts_n_o moves on the same
  // edge as level_o.
  always_comb begin
    rts_state_d = rts_state_q;
    if (flush_i) begin
      rts_state_d = RTS_ASSERTED;
    end else begin
      case (rts_state_q)
        RTS_ASSERTED: begin
          if (level_d >= LVL_HIGH) begin
            rts_state_d = RTS_DEASSERTED;
          end else begin
            rts_state_d = RTS_ASSERTED;
          end
        end
        RTS_DEASSERTED: begin
          if (level_d <= LVL_LOW) begin
            rts_state_d = RTS_ASSERTED;
          end else begin
            rts_state_d = RTS_DEASSERTED;
          end
        end
        default: rts_state_d = RTS_ASSERTED;
      endcase
    end
    rts_n_d = (rts_state_d == RTS_DEASSERTED);
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      level_q     <= LVL_ZERO;
      overrun_q   <= 1'b0;
      rts_state_q <= RTS_ASSERTED;
      rts_n_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      rts_state_q <= rts_state_d;
      rts_n_q     <= rts_n_d;
    end
  end

  // Character storage; writes are suppressed while reset is applied.
  always_ff @(posedge clk) begin
    if (mem_we_s && rst_n) begin
      mem_q[wr_ptr_q] <= {wr_err_i, wr_d_i};
    end
  end

  // Show-ahead head entry and status outputs.
  always_comb begin
    rd_entry_s   = mem_q[rd_ptr_q];
    rd_d_o       = rd_entry_s[8:0];
    rd_err_o     = rd_entry_s[10:9];
    level_o      = level_q;
    empty_o      = (level_q == LVL_ZERO);
    full_o       = (level_q == LVL_FULL);
    rd_valid_o   = (level_q != LVL_ZERO);
    overrun_o    = overrun_q;
    rts_n_o      = rts_n_q;
    thresh_irq_o = (thresh_i != LVL_ZERO) && (level_q >= thresh_i);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with a queue scoreboard. Each step drives
// inputs on the falling edge, compares any popped head against the queue
// front, advances a reference model of level/overrun/RTS, and checks all
// status outputs on the following falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int HI_WM = 12;
  localparam int LO_WM = 4;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [8:0]    wr_d_i;
  logic [1:0]    wr_err_i;
  logic          wr_valid_i;
  logic [8:0]    rd_d_o;
  logic [1:0]    rd_err_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic          flush_i;
  logic [LW-1:0] thresh_i;
  logic [LW-1:0] level_o;
  logic          empty_o;
  logic          full_o;
  logic          overrun_o;
  logic          overrun_clr_i;
  logic          thresh_irq_o;
  logic          rts_n_o;

  logic [10:0]   sb_q[$];
  logic          m_ovr;
  logic          m_rts;
  int            n_assert = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH       (DEPTH),
    .RTS_HIGH_WM (HI_WM),
    .RTS_LOW_WM  (LO_WM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_d_i        (wr_d_i),
    .wr_err_i      (wr_err_i),
    .wr_valid_i    (wr_valid_i),
    .rd_d_o        (rd_d_o),
    .rd_err_o      (rd_err_o),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .flush_i       (flush_i),
    .thresh_i      (thresh_i),
    .level_o       (level_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
    .thresh_irq_o  (thresh_irq_o),
    .rts_n_o       (rts_n_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = sb_q.size();
    chk({tag, ":level"},    32'(level_o),    32'(sz));
    chk({tag, ":empty"},    32'(empty_o),    32'(sz == 0));
    chk({tag, ":full"},     32'(full_o),     32'(sz == DEPTH));
    chk({tag, ":rd_valid"}, 32'(rd_valid_o), 32'(sz != 0));
    chk({tag, ":overrun"},  32'(overrun_o),  32'(m_ovr));
    chk({tag, ":rts_n"},    32'(rts_n_o),    32'(m_rts));
    chk({tag, ":irq"},      32'(thresh_irq_o),
        32'((thresh_i != 0) && (sz >= int'(thresh_i))));
  endtask

  task automatic step(input string tag, input logic wr, input logic [8:0] d,
                      input logic [1:0] e, input logic rd, input logic fl,
                      input logic clr);
    int          sz;
    int          nl;
    logic        hs;
    logic        acc;
    logic [10:0] head;
    wr_valid_i    = wr;
    wr_d_i        = d;
    wr_err_i      = e;
    rd_ready_i    = rd;
    flush_i       = fl;
    overrun_clr_i = clr;
    sz  = sb_q.size();
    hs  = rd && (sz > 0);
    acc = wr && !fl && ((sz < DEPTH) || hs);
    if (hs) begin
      head = sb_q.pop_front();
      chk({tag, ":rd_d"},   32'(rd_d_o),   32'(head[8:0]));
      chk({tag, ":rd_err"}, 32'(rd_err_o), 32'(head[10:9]));
    end
    if (fl) begin
      sb_q.delete();
    end else if (acc) begin
      sb_q.push_back({e, d});
    end
    if (wr && !fl && !acc) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    nl = sb_q.size();
    if (fl) m_rts = 1'b0;
    else if (!m_rts && nl >= HI_WM) m_rts = 1'b1;
    else if (m_rts && nl <= LO_WM) m_rts = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr_valid_i    = 1'b0;
    rd_ready_i    = 1'b0;
    flush_i       = 1'b0;
    overrun_clr_i = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n      = 1'b0;
    wr_valid_i = 1'b1;
    wr_d_i     = 9'h1FF;
    rd_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    sb_q.delete();
    m_ovr = 1'b0;
    m_rts = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr_d_i = 9'h000; wr_err_i = 2'd0; wr_valid_i = 1'b0;
    rd_ready_i = 1'b0; flush_i = 1'b0; thresh_i = 5'd0; overrun_clr_i = 1'b0;
    m_ovr = 1'b0; m_rts = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Three characters in, popped back in order with rd_ready held high.
    step("w1", 1'b1, 9'h041, 2'd0, 1'b0, 1'b0, 1'b0);
    step("w2", 1'b1, 9'h142, 2'd1, 1'b0, 1'b0, 1'b0);
    step("w3", 1'b1, 9'h043, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("lvl_after_3", 32'(level_o), 32'd3);
    for (int i = 0; i < 3; i++) step("pop3", 1'b0, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("empty_after_pops", 32'(empty_o), 32'd1);
    step("pop_empty", 1'b0, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Fill to full; the 17th write is dropped even with a concurrent clear.
    for (int i = 1; i <= 16; i++) begin
      step("fill", 1'b1, 9'(i * 37 + 5), 2'(i), 1'b0, 1'b0, 1'b0);
      if (i == 11) chk("rts_at11", 32'(rts_n_o), 32'd0);
      if (i == 12) chk("rts_at12", 32'(rts_n_o), 32'd1);
    end
    chk("full_at16", 32'(full_o), 32'd1);
    step("drop17", 1'b1, 9'h1EE, 2'd3, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_beats_clr", 32'(overrun_o), 32'd1);
    step("ovr_clr", 1'b0, 9'h000, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(overrun_o), 32'd0);

    // Full with simultaneous pop and write: both succeed.
    step("full_rw", 1'b1, 9'h1AA, 2'd3, 1'b1, 1'b0, 1'b0);
    chk("full_rw_lvl", 32'(level_o), 32'd16);
    chk("full_rw_ovr", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);
      if (level_o == 5'd5) chk("rts_at5", 32'(rts_n_o), 32'd1);
      if (level_o == 5'd4) chk("rts_at4", 32'(rts_n_o), 32'd0);
    end

    // Threshold interrupt.
    thresh_i = 5'd3;
    step("th1", 1'b1, 9'h011, 2'd0, 1'b0, 1'b0, 1'b0);
    step("th2", 1'b1, 9'h012, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("irq_below", 32'(thresh_irq_o), 32'd0);
    step("th3", 1'b1, 9'h013, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("irq_at", 32'(thresh_irq_o), 32'd1);
    thresh_i = 5'd0;
    #1;
    chk("irq_disabled", 32'(thresh_irq_o), 32'd0);

    // Flush with 10 entries and a concurrent write.
    for (int i = 0; i < 7; i++) step("to10", 1'b1, 9'(i + 9'h0A0), 2'(i), 1'b0, 1'b0, 1'b0);
    chk("lvl10", 32'(level_o), 32'd10);
    step("flush10", 1'b1, 9'h0FF, 2'd1, 1'b1, 1'b1, 1'b0);
    chk("flush10_lvl", 32'(level_o), 32'd0);

    // Flush from full/deasserted-RTS with overrun set: RTS reasserts, overrun holds.
    for (int i = 0; i < 17; i++) step("refill", 1'b1, 9'(i * 11), 2'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("refill_ovr", 32'(overrun_o), 32'd1);
    step("flush_full", 1'b1, 9'h155, 2'd2, 1'b0, 1'b1, 1'b0);
    chk("flush_ovr_held", 32'(overrun_o), 32'd1);
    chk("flush_rts", 32'(rts_n_o), 32'd0);
    step("post_flush_w", 1'b1, 9'h0C3, 2'd1, 1'b0, 1'b0, 1'b0);
    step("post_flush_r", 1'b0, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 13; i++) step("pre_rst", 1'b1, 9'(i + 9'h120), 2'(i), 1'b0, 1'b0, 1'b0);
    thresh_i = 5'd1;
    do_reset("mid_reset");
    step("post_rst_w", 1'b1, 9'h07E, 2'd3, 1'b0, 1'b0, 1'b0);
    step("post_rst_r", 1'b0, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
